// File: rtl/seq_detect_counter_pkg.sv
// Shared defaults for the multi-channel pattern detector / hit counter.
package seq_detect_counter_pkg;

  localparam int unsigned           DEF_CH       = 4;
  localparam int unsigned           DEF_PAT_W    = 3;
  localparam logic [DEF_PAT_W-1:0]  DEF_PATTERN  = 3'b101;
  localparam int unsigned           DEF_CNT_W    = 8;
  localparam bit                    DEF_OVERLAP  = 1'b1;
  localparam bit                    DEF_SATURATE = 1'b1;

endpackage

// File: rtl/seq_detect_channel.sv
// One detector channel: strobed shift history, fill qualifier, match pulse,
// hit counter (saturate or wrap) and sticky overflow flag.
module seq_detect_channel
  import seq_detect_counter_pkg::*;
#(
  parameter int unsigned       PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN  = PAT_W'(DEF_PATTERN),
  parameter int unsigned       CNT_W    = DEF_CNT_W,
  parameter bit                OVERLAP  = DEF_OVERLAP,
  parameter bit                SATURATE = DEF_SATURATE
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic             din_i,
  output logic             hit_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             ovf_o
);

  localparam int unsigned      FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              hit_q, hit_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [PAT_W-1:0]  next_hist_c;
  logic              match_c;

  // Fill must be full so the reset zeros in hist never produce a match.
  assign next_hist_c = {hist_q[PAT_W-2:0], din_i};
  assign match_c     = en_i && !clr_i && (next_hist_c == PATTERN) && (fill_q == FILL_MAX);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    hit_d  = 1'b0;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;

    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (en_i) begin
      hist_d = next_hist_c;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
      hit_d = match_c;
      if (match_c) begin
        if (!OVERLAP) begin
          fill_d = '0;
        end
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          ovf_d = 1'b1;
          if (!SATURATE) begin
            cnt_d = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
      fill_q <= '0;
      hit_q  <= 1'b0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      hit_q  <= hit_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign hit_o = hit_q;
  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/seq_detect_counter.sv
// Multi-channel pattern detector: CH independent channels on a shared sample
// strobe, each with its own hit pulse, hit counter and sticky overflow.
module seq_detect_counter
  import seq_detect_counter_pkg::*;
#(
  parameter int unsigned       CH       = DEF_CH,
  parameter int unsigned       PAT_W    = DEF_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN  = PAT_W'(DEF_PATTERN),
  parameter int unsigned       CNT_W    = DEF_CNT_W,
  parameter bit                OVERLAP  = DEF_OVERLAP,
  parameter bit                SATURATE = DEF_SATURATE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr,
  input  logic [CH-1:0]       din,
  output logic [CH-1:0]       hit,
  output logic [CH*CNT_W-1:0] cnt,
  output logic [CH-1:0]       ovf
);

  if (PAT_W < 2) begin : g_bad_pat_w
    $error("seq_detect_counter: PAT_W must be at least 2");
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    seq_detect_channel #(
      .PAT_W    (PAT_W),
      .PATTERN  (PATTERN),
      .CNT_W    (CNT_W),
      .OVERLAP  (OVERLAP),
      .SATURATE (SATURATE)
    ) u_channel (
      .clk_i (clk),
      .rst_i (reset),
      .en_i  (en),
      .clr_i (clr),
      .din_i (din[i]),
      .hit_o (hit[i]),
      .cnt_o (cnt[i*CNT_W +: CNT_W]),
      .ovf_o (ovf[i])
    );
  end

endmodule

// File: tb/tb_seq_detect_counter.sv
// Directed bench: five parameter variants share one stimulus stream.
module tb_seq_detect_counter;

  logic       clk = 1'b0;
  logic       reset, en, clr;
  logic [3:0] din;

  logic [3:0]  hit_def, hit_novl, hit_sat, hit_wrap, hit_p001;
  logic [31:0] cnt_def, cnt_novl, cnt_p001;
  logic [7:0]  cnt_sat, cnt_wrap;
  logic [3:0]  ovf_def, ovf_novl, ovf_sat, ovf_wrap, ovf_p001;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  always #5 clk = ~clk;

  seq_detect_counter u_def (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .din(din),
    .hit(hit_def), .cnt(cnt_def), .ovf(ovf_def));

  seq_detect_counter #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .din(din),
    .hit(hit_novl), .cnt(cnt_novl), .ovf(ovf_novl));

  seq_detect_counter #(.CNT_W(2), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .din(din),
    .hit(hit_sat), .cnt(cnt_sat), .ovf(ovf_sat));

  seq_detect_counter #(.CNT_W(2), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .din(din),
    .hit(hit_wrap), .cnt(cnt_wrap), .ovf(ovf_wrap));

  seq_detect_counter #(.PATTERN(3'b001)) u_p001 (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .din(din),
    .hit(hit_p001), .cnt(cnt_p001), .ovf(ovf_p001));

  bit t1_din  [5] = '{1, 0, 1, 0, 1};
  bit t1_def  [5] = '{0, 0, 1, 0, 1};
  bit t1_novl [5] = '{0, 0, 1, 0, 0};
  bit t5_din  [6] = '{1, 0, 1, 0, 0, 1};
  bit t5_def  [6] = '{0, 0, 1, 0, 0, 0};
  bit t5_p001 [6] = '{0, 0, 0, 0, 0, 1};
  logic [1:0] sat_seq  [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
  logic [1:0] wrap_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  bit         ovf_seq  [5] = '{0, 0, 0, 1, 1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one cycle between edges, then observe 1 time unit after the edge.
  task automatic step(input logic [3:0] d, input logic e, input logic c);
    @(negedge clk);
    din = d; en = e; clr = c;
    @(posedge clk);
    #1;
    en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; en = 1'b0; clr = 1'b0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hit",  32'(hit_def), 32'h0);
    check("rst_cnt",  cnt_def, 32'h0);
    check("rst_ovf",  32'(ovf_def), 32'h0);
    check("rst_csat", 32'(cnt_sat), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // 1,0,1,0,1 on ch0: overlap hits on 3rd and 5th, non-overlap only 3rd
    for (int i = 0; i < 5; i++) begin
      step({3'b000, t1_din[i]}, 1'b1, 1'b0);
      check("t1_hit_def",  32'(hit_def),  32'({3'b000, t1_def[i]}));
      check("t1_hit_novl", 32'(hit_novl), 32'({3'b000, t1_novl[i]}));
      check("t1_hit_p001", 32'(hit_p001), 32'h0);
    end
    check("t1_cnt_def",  cnt_def,  32'h2);
    check("t1_cnt_novl", cnt_novl, 32'h1);
    check("t1_ovf_novl", 32'(ovf_novl), 32'h0);
    step(4'h0, 1'b0, 1'b0);
    check("t1_hit_drop", 32'(hit_def), 32'h0);

    // clr wins over a strobe that would otherwise match
    step(4'h0, 1'b1, 1'b0);
    step(4'h1, 1'b1, 1'b1);
    check("clr_hit_def",  32'(hit_def),  32'h0);
    check("clr_hit_novl", 32'(hit_novl), 32'h0);
    check("clr_cnt_def",  cnt_def,  32'h0);
    check("clr_cnt_novl", cnt_novl, 32'h0);
    check("clr_cnt_sat",  32'(cnt_sat), 32'h0);
    for (int i = 0; i < 6; i++) begin
      step({3'b000, t5_din[i]}, 1'b1, 1'b0);
      check("refill_hit_def",  32'(hit_def),  32'({3'b000, t5_def[i]}));
      check("refill_hit_p001", 32'(hit_p001), 32'({3'b000, t5_p001[i]}));
    end
    check("refill_cnt_def",  cnt_def,  32'h1);
    check("refill_cnt_p001", cnt_p001, 32'h1);
    check("refill_ovf_p001", 32'(ovf_p001), 32'h0);

    // Idle: din toggles without a strobe; nothing may move
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      din = i[0] ? 4'hF : 4'h0;
      en  = 1'b0;
      @(posedge clk);
      #1;
      check("idle_hit", 32'(hit_def), 32'h0);
      check("idle_cnt", cnt_def, 32'h1);
    end
    step(4'h0, 1'b1, 1'b0);
    check("idle_first_hit", 32'(hit_def), 32'h0);
    step(4'h1, 1'b1, 1'b0);
    check("idle_second_hit", 32'(hit_def), 32'h1);
    check("idle_cnt_after",  cnt_def, 32'h2);

    // Five overlapping matches on ch1 with 2-bit counters
    step(4'h0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) begin
      step({2'b00, ~i[0], 1'b0}, 1'b1, 1'b0);
      if (i >= 2 && !i[0]) begin
        check("sat_hit",  32'(hit_sat),     32'h2);
        check("sat_cnt",  32'(cnt_sat[3:2]),  32'(sat_seq[i/2-1]));
        check("wrap_cnt", 32'(cnt_wrap[3:2]), 32'(wrap_seq[i/2-1]));
        check("sat_ovf",  32'(ovf_sat[1]),    32'(ovf_seq[i/2-1]));
        check("wrap_ovf", 32'(ovf_wrap[1]),   32'(ovf_seq[i/2-1]));
      end else begin
        check("sat_nohit", 32'(hit_sat), 32'h0);
      end
    end
    step(4'h0, 1'b0, 1'b0);
    step(4'h0, 1'b0, 1'b0);
    check("ovf_sticky_sat",  32'(ovf_sat),  32'h2);
    check("ovf_sticky_wrap", 32'(ovf_wrap), 32'h2);
    check("ovf_def_clear",   32'(ovf_def),  32'h0);
    check("cnt_def_ch1",     cnt_def, 32'h0000_0500);

    // Asynchronous reset mid-pattern, then a clean restart
    step(4'h1, 1'b1, 1'b0);
    step(4'h0, 1'b1, 1'b0);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("areset_cnt_def",  cnt_def, 32'h0);
    check("areset_cnt_sat",  32'(cnt_sat), 32'h0);
    check("areset_ovf_sat",  32'(ovf_sat), 32'h0);
    check("areset_ovf_wrap", 32'(ovf_wrap), 32'h0);
    check("areset_hit",      32'(hit_def), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    step(4'h1, 1'b1, 1'b0);
    check("restart_hit1", 32'(hit_def), 32'h0);
    step(4'h0, 1'b1, 1'b0);
    check("restart_hit2", 32'(hit_def), 32'h0);
    step(4'h1, 1'b1, 1'b0);
    check("restart_hit3", 32'(hit_def), 32'h1);
    check("restart_cnt",  cnt_def, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
